oam_dma: RTL
============

// Module: oam_dma
// PURPOSE
//  OAM DMA engine at register 0xFF46. A CPU write of value XX copies 160 bytes, XX00-XX9F, into OAM at FE00-FE9F.
//  Sits directly upstream of OAM and downstream of the work-RAM/cartridge data bus.
//  Sources reads through the shared memory bus; work RAM at 0xC000 is the usual source.
//  While transferring, it owns the bus address; the top-level mux drives dma_addr onto the bus when dma_active is high.
// PARAMETERS
//  CYCLES_PER_BYTE  4       clk cycles per transferred byte (one M-cycle); legal range >=1
//  NUM_BYTES        160     bytes per transfer; OAM index width is 8 bits
//  REG_ADDR         'hFF46  CPU-visible register address
// PORTS
//  clk               in   1   system clock; all state changes on posedge
//  reset             in   1   synchronous, active-high reset
//  abs_addr          in   16  CPU bus address
//  data_w            in   8   CPU write data
//  write_enable      in   1   CPU write strobe
//  data_r            out  8   register readback (last value written to REG_ADDR)
//  data_active       out  1   high when !write_enable && abs_addr==REG_ADDR
//  dma_active        out  1   high while DMA owns the memory bus (XFER state)
//  dma_addr          out  16  source address to memory bus; 0 when not in XFER
//  mem_data_r        in   8   read data returned by the memory bus (RAM updates it on negedge)
//  oam_addr          out  8   OAM byte index 0..NUM_BYTES-1
//  oam_data          out  8   byte to write; equals mem_data_r
//  oam_we            out  1   OAM write strobe; OAM samples on posedge
//  busy              out  1   high in START or XFER
// BEHAVIOUR
//  Reset values
//   - state=IDLE; src_hi (data_r)=8'hFF; idx=0; phase=0.
//   - dma_active=0, dma_addr=0, oam_we=0, busy=0.
//  Register write
//   - A register write is a posedge with write_enable && abs_addr==REG_ADDR.
//   - At that edge: src_hi<=data_w, idx<=0, phase<=0, state<=START.
//   - This applies from any state; a write in START or XFER restarts the transfer from the new base.
//  Source mirror
//   - Effective high byte eff = (src_hi>=8'hE0) ? src_hi-8'h20 : src_hi.
//   - Example: E3 reads C300.
//  START state
//   - Lasts CYCLES_PER_BYTE cycles with dma_active=0 and busy=1, then moves to XFER with phase=0.
//  XFER state
//   - dma_active=1; dma_addr={eff, idx}.
//   - phase counts 0..CYCLES_PER_BYTE-1; the address is held stable for the whole byte period.
//   - oam_we=1 (combinational) only when phase==CYCLES_PER_BYTE-1; at that posedge OAM captures oam_data at oam_addr=idx.
//   - At the last phase: if idx==NUM_BYTES-1, go to IDLE; else idx<=idx+1, phase<=0.
//  Latency
//   - dma_active rises CYCLES_PER_BYTE cycles after the write edge.
//   - dma_active stays high for exactly NUM_BYTES*CYCLES_PER_BYTE cycles.
//   - Exactly NUM_BYTES oam_we pulses per uninterrupted transfer.
//  Simultaneous events
//   - If a register write coincides with an oam_we cycle, that byte's OAM write still completes; the restart takes effect at the same edge.
//   - A register write together with reset: reset wins.
//  Reset mid-transfer
//   - Reset forces IDLE at the next posedge.
//   - No further oam_we; partial OAM contents are left as written.
//  Readback
//   - data_r is registered and returns src_hi in every state.
//   - No CPU bus arbitration is done here; the CPU-side blocking of non-HRAM accesses during dma_active belongs to the top level.
// TESTING
//  1. Preload C100+i=i^8'h5A; write C1 to FF46 -> OAM[i]==i^8'h5A for i=0..159; exactly 160 oam_we pulses.
//  2. Timing, CPB=4: write at cycle 0 -> dma_active rises at cycle 4, falls at cycle 644; busy falls at the same cycle.
//  3. Write E3 -> dma_addr runs C300..C39F; read FF46 -> data_r=E3, data_active=1.
//  4. Write C1, then write C2 after 50 bytes -> next dma_addr=C200; OAM[0..159] end with C200..C29F data; 210 oam_we pulses total.
//  5. Assert reset after 20 bytes -> next cycle dma_active=0, busy=0, data_r=FF; OAM[20..159] unchanged.
//  6. Sweep CPB=1 and CPB=2 -> same OAM result as scenario 1; dma_active duration = 160*CPB.

Source files
------------

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to the DMA register copies NUM_BYTES bytes from
// {src_hi, 8'h00} onwards into OAM, one byte every CYCLES_PER_BYTE clocks.
module oam_dma #(
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter int unsigned NUM_BYTES       = 160,
    parameter logic [15:0] REG_ADDR        = 16'hFF46
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] abs_addr,
    input  logic [7:0]  data_w,
    input  logic        write_enable,
    output logic [7:0]  data_r,
    output logic        data_active,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    input  logic [7:0]  mem_data_r,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        busy
);

    localparam int unsigned PHASE_W = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0] IDX_LAST = 8'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [7:0]           src_hi;
    logic [7:0]           eff_hi;
    logic [7:0]           idx;
    logic [PHASE_W-1:0]   phase;
    logic                 reg_wr;
    logic                 phase_last;
    logic                 idx_last;

    assign reg_wr     = write_enable && (abs_addr == REG_ADDR);
    assign phase_last = (phase == PHASE_LAST);
    assign idx_last   = (idx == IDX_LAST);
    // Echo region E000-FDFF mirrors work RAM at C000-DDFF.
    assign eff_hi     = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a register write restarts from any state
    always_comb begin
        state_nx = state;
        if (reg_wr) begin
            state_nx = START;
        end else begin
            case (state)
                START:   if (phase_last) state_nx = XFER;
                XFER:    if (phase_last && idx_last) state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end

    // Source page, byte index and per-byte phase counter
    always_ff @(posedge clk) begin
        if (reset) begin
            src_hi <= 8'hFF;
            idx    <= 8'h00;
            phase  <= '0;
        end else if (reg_wr) begin
            src_hi <= data_w;
            idx    <= 8'h00;
            phase  <= '0;
        end else begin
            case (state)
                START: begin
                    phase <= phase_last ? '0 : phase + PHASE_W'(1);
                end
                XFER: begin
                    if (phase_last) begin
                        phase <= '0;
                        if (!idx_last) idx <= idx + 8'd1;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                default: phase <= '0;
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        dma_active = 1'b0;
        dma_addr   = 16'h0000;
        oam_we     = 1'b0;
        busy       = 1'b0;
        case (state)
            START: busy = 1'b1;
            XFER: begin
                busy       = 1'b1;
                dma_active = 1'b1;
                dma_addr   = {eff_hi, idx};
                oam_we     = phase_last;
            end
            default: ;
        endcase
    end

    assign data_r      = src_hi;
    assign data_active = !write_enable && (abs_addr == REG_ADDR);
    assign oam_addr    = idx;
    assign oam_data    = mem_data_r;

endmodule
